scaled_frame_reader: RTL and testbench

Parametrised frame-buffer reader between the VGA raster controller and the pixel BRAM. It maps each display coordinate to a nearest-neighbour source address (src = floor(dst·SRC/DISP) per axis) using multiplier-free incremental DDA steppers, and selects between stretch and native 1:1 modes. It delays HS/VS/visible to align them with BRAM read data, and produces the final registered pixel stream for the VGA pins.

---
 rtl/scaled_frame_reader_pkg.sv | 22 ++
 rtl/scale_dda.sv | 61 ++++++
 rtl/scaled_frame_reader.sv | 180 ++++++++++++++++++
 tb/tb_scaled_frame_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaled_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hp2vga_defs (package)
// Brief    : Shared panel/source constants, MODE encoding and coordinate width.
// Revision : 1.0
// ============================================================================
package hp2vga_defs;

    localparam int COORD_W    = 12;

    localparam int DEF_DISP_W = 1024;
    localparam int DEF_DISP_H = 600;
    localparam int DEF_SRC_W  = 576;
    localparam int DEF_SRC_H  = 378;

    typedef enum logic {
        MODE_STRETCH = 1'b0,
        MODE_NATIVE  = 1'b1
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/scale_dda.sv
`default_nettype none
// ============================================================================
// Module   : scale_dda
// Brief    : Single-axis nearest-neighbour DDA stepper; src = floor(dst*SRC/DST).
// Revision : 1.0
// ============================================================================
module scale_dda
    import hp2vga_defs::*;
#(
    parameter int SRC   = DEF_SRC_W,
    parameter int DST   = DEF_DISP_W,
    parameter int OUT_W = COORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_step,
    input  mode_e            i_mode,
    output logic [OUT_W-1:0] o_src,
    output logic             o_carry
);

    localparam int ACC_W = $clog2(DST) + 1;
    localparam logic [ACC_W-1:0] SRC_INC  = ACC_W'(SRC);
    localparam logic [ACC_W-1:0] DST_WRAP = ACC_W'(DST);
    localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic [OUT_W-1:0] r_src;

    // Carry is combinational so the caller can advance dependent state on the same edge.
    always_comb begin
        w_sum   = r_acc + SRC_INC;
        o_carry = i_step && !i_clear && ((i_mode == MODE_NATIVE) || (w_sum >= DST_WRAP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_src <= '0;
        end else if (i_en) begin
            if (i_clear) begin
                r_acc <= '0;
                r_src <= '0;
            end else if (i_step) begin
                if (o_carry) begin
                    r_src <= r_src + ONE;
                end
                if (i_mode == MODE_STRETCH) begin
                    r_acc <= o_carry ? (w_sum - DST_WRAP) : w_sum;
                end
            end
        end
    end

    assign o_src = r_src;

endmodule
`default_nettype wire

// File: rtl/scaled_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : scaled_frame_reader
// Brief    : Raster-to-BRAM reader with stretch/native scaling and aligned sync.
//            Optional macro HP2VGA_BORDER_EN draws an all-ones frame border.
// Revision : 1.0
// ============================================================================
module scaled_frame_reader
    import hp2vga_defs::*;
#(
    parameter int SRC_W    = DEF_SRC_W,
    parameter int SRC_H    = DEF_SRC_H,
    parameter int DISP_W   = DEF_DISP_W,
    parameter int DISP_H   = DEF_DISP_H,
    parameter int ADDR_W   = 18,
    parameter int PIX_W    = 8,
    parameter int BRAM_LAT = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               MODE,
    input  logic [COORD_W-1:0] VGA_X,
    input  logic [COORD_W-1:0] VGA_Y,
    input  logic               VGA_VISIBLE,
    input  logic               VGA_HS_I,
    input  logic               VGA_VS_I,
    output logic [ADDR_W-1:0]  BRAM_ADDR,
    input  logic [PIX_W-1:0]   BRAM_DOUT,
    output logic [PIX_W-1:0]   PIX_O,
    output logic               VGA_HS_O,
    output logic               VGA_VS_O,
    output logic               PIX_VALID_O
);

    localparam int LAT = 3 + BRAM_LAT;
    localparam int PRE = LAT - 1;

    localparam logic [COORD_W-1:0] SRC_W_C  = COORD_W'(SRC_W);
    localparam logic [COORD_W-1:0] SRC_H_C  = COORD_W'(SRC_H);
    localparam logic [COORD_W-1:0] DISP_W_C = COORD_W'(DISP_W);
    localparam logic [COORD_W-1:0] DISP_H_C = COORD_W'(DISP_H);
    localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);

    mode_e              r_mode;
    mode_e              w_mode;
    logic               w_frame_start;
    logic               w_line_start;
    logic               w_region;
    logic               w_last_x;
    logic               r_last_d1;
    logic [COORD_W-1:0] w_lim_x;
    logic [COORD_W-1:0] w_lim_y;
    logic [COORD_W-1:0] w_src_x;
    logic [COORD_W-1:0] w_src_y;
    logic               w_x_carry;
    logic               w_y_carry;
    logic               w_src_ok;
    logic [ADDR_W-1:0]  r_row_base;
    logic [ADDR_W-1:0]  r_pix_addr;
    logic [ADDR_W-1:0]  r_addr;
    logic [PRE-1:0]     r_vis_sr;
    logic [LAT-1:0]     r_hs_sr;
    logic [LAT-1:0]     r_vs_sr;
    logic [PIX_W-1:0]   r_pix;
    logic [PIX_W-1:0]   w_pix_next;
    logic               r_valid;
`ifdef HP2VGA_BORDER_EN
    logic               w_border;
    logic [PRE-1:0]     r_bdr_sr;
`endif

    always_comb begin
        w_frame_start = VGA_VISIBLE && (VGA_X == '0) && (VGA_Y == '0);
        w_line_start  = VGA_VISIBLE && (VGA_X == '0);
        // The frame-start pixel itself already obeys the newly latched mode.
        w_mode        = w_frame_start ? mode_e'(MODE) : r_mode;
        w_lim_x       = (w_mode == MODE_NATIVE) ? SRC_W_C : DISP_W_C;
        w_lim_y       = (w_mode == MODE_NATIVE) ? SRC_H_C : DISP_H_C;
        w_region      = VGA_VISIBLE && (VGA_X < w_lim_x) && (VGA_Y < w_lim_y);
        w_last_x      = w_region && (VGA_X == (w_lim_x - ONE_C));
        // Keeps the address inside the image after a raster jump until the next reload.
        w_src_ok      = (w_src_x < SRC_W_C) && (w_src_y < SRC_H_C);
`ifdef HP2VGA_BORDER_EN
        w_border      = w_region && ((VGA_X == '0) || (VGA_X == (w_lim_x - ONE_C)) ||
                                     (VGA_Y == '0) || (VGA_Y == (w_lim_y - ONE_C)));
        w_pix_next    = !r_vis_sr[PRE-1] ? '0 :
                        (r_bdr_sr[PRE-1] ? '1 : BRAM_DOUT);
`else
        w_pix_next    = r_vis_sr[PRE-1] ? BRAM_DOUT : '0;
`endif
    end

    scale_dda #(
        .SRC   (SRC_W),
        .DST   (DISP_W),
        .OUT_W (COORD_W)
    ) u_dda_x (
        .clk     (CLK),
        .rst     (RESET),
        .i_en    (ENABLE),
        .i_clear (w_line_start),
        .i_step  (w_region),
        .i_mode  (w_mode),
        .o_src   (w_src_x),
        .o_carry (w_x_carry)
    );

    // Y steps one cycle after the last pixel so that pixel still sees the old row.
    scale_dda #(
        .SRC   (SRC_H),
        .DST   (DISP_H),
        .OUT_W (COORD_W)
    ) u_dda_y (
        .clk     (CLK),
        .rst     (RESET),
        .i_en    (ENABLE),
        .i_clear (w_frame_start),
        .i_step  (r_last_d1),
        .i_mode  (r_mode),
        .o_src   (w_src_y),
        .o_carry (w_y_carry)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mode     <= MODE_STRETCH;
            r_last_d1  <= 1'b0;
            r_row_base <= '0;
            r_pix_addr <= '0;
            r_addr     <= '0;
            r_vis_sr   <= '0;
            r_hs_sr    <= '0;
            r_vs_sr    <= '0;
            r_pix      <= '0;
            r_valid    <= 1'b0;
`ifdef HP2VGA_BORDER_EN
            r_bdr_sr   <= '0;
`endif
        end else if (ENABLE) begin
            if (w_frame_start) begin
                r_mode <= mode_e'(MODE);
            end
            r_last_d1 <= w_last_x;

            if (w_frame_start) begin
                r_row_base <= '0;
            end else if (w_y_carry) begin
                r_row_base <= r_row_base + ROW_STEP;
            end

            // Running row_base + src_x, advanced by the x carry instead of an adder.
            if (w_line_start) begin
                r_pix_addr <= w_frame_start ? '0 : r_row_base;
            end else if (w_x_carry) begin
                r_pix_addr <= r_pix_addr + ADDR_ONE;
            end

            r_addr   <= (r_vis_sr[0] && w_src_ok) ? r_pix_addr : '0;
            r_vis_sr <= {r_vis_sr[PRE-2:0], w_region};
            r_hs_sr  <= {r_hs_sr[LAT-2:0], VGA_HS_I};
            r_vs_sr  <= {r_vs_sr[LAT-2:0], VGA_VS_I};
            r_pix    <= w_pix_next;
            r_valid  <= r_vis_sr[PRE-1];
`ifdef HP2VGA_BORDER_EN
            r_bdr_sr <= {r_bdr_sr[PRE-2:0], w_border};
`endif
        end
    end

    assign BRAM_ADDR   = r_addr;
    assign PIX_O       = r_pix;
    assign PIX_VALID_O = r_valid;
    assign VGA_HS_O    = r_hs_sr[LAT-1];
    assign VGA_VS_O    = r_vs_sr[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_scaled_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaled_frame_reader
// Brief    : Directed self-checking bench for scaled_frame_reader (defaults).
// Revision : 1.0
// ============================================================================
module tb_scaled_frame_reader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        MODE;
    logic [11:0] VGA_X;
    logic [11:0] VGA_Y;
    logic        VGA_VISIBLE;
    logic        VGA_HS_I;
    logic        VGA_VS_I;
    logic [17:0] BRAM_ADDR;
    logic [7:0]  BRAM_DOUT;
    logic [7:0]  PIX_O;
    logic        VGA_HS_O;
    logic        VGA_VS_O;
    logic        PIX_VALID_O;
    logic [7:0]  r_bram_q = 8'h00;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // One-cycle BRAM model: data = low address byte XOR 0xA5.
    always @(posedge CLK) r_bram_q <= BRAM_ADDR[7:0] ^ 8'hA5;
    assign BRAM_DOUT = r_bram_q;

    scaled_frame_reader u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .MODE        (MODE),
        .VGA_X       (VGA_X),
        .VGA_Y       (VGA_Y),
        .VGA_VISIBLE (VGA_VISIBLE),
        .VGA_HS_I    (VGA_HS_I),
        .VGA_VS_I    (VGA_VS_I),
        .BRAM_ADDR   (BRAM_ADDR),
        .BRAM_DOUT   (BRAM_DOUT),
        .PIX_O       (PIX_O),
        .VGA_HS_O    (VGA_HS_O),
        .VGA_VS_O    (VGA_VS_O),
        .PIX_VALID_O (PIX_VALID_O)
    );

    task automatic drive(input int x, input int y, input bit vis);
        VGA_X       = 12'(x);
        VGA_Y       = 12'(y);
        VGA_VISIBLE = vis;
        @(posedge CLK);
        #1;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(1100, 700, 1'b0);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        blank(3);
        checks++; if (BRAM_ADDR !== 18'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", BRAM_ADDR); end
        checks++; if (PIX_O !== 8'h00) begin failures++; $display("FAIL reset_pix: got %h expected 00", PIX_O); end
        checks++; if (VGA_HS_O !== 1'b0) begin failures++; $display("FAIL reset_hs: got %b expected 0", VGA_HS_O); end
        checks++; if (VGA_VS_O !== 1'b0) begin failures++; $display("FAIL reset_vs: got %b expected 0", VGA_VS_O); end
        checks++; if (PIX_VALID_O !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", PIX_VALID_O); end
        RESET = 1'b0;
        blank(2);
    endtask

    task automatic test_stretch_line();
        logic [17:0] ea;
        logic [7:0]  ep;
        MODE = 1'b0;
        blank(4);
        for (int x = 0; x < 1024; x++) begin
            drive(x, 0, 1'b1);
            // Address of pixel x-1 and pixel of x-3 are visible now.
            if (x >= 1 && x <= 3) begin
                ea = (x == 3) ? 18'd1 : 18'd0;
                checks++;
                if (BRAM_ADDR !== ea) begin failures++; $display("FAIL stretch_addr_x%0d: got %0d expected %0d", x - 1, BRAM_ADDR, ea); end
            end
            if (x == 4 || x == 5 || x == 8) begin
                ep = (x == 4) ? 8'hA5 : ((x == 5) ? 8'hA4 : 8'hA7);
                checks++;
                if (PIX_O !== ep) begin failures++; $display("FAIL stretch_pix_x%0d: got %h expected %h", x - 3, PIX_O, ep); end
            end
            if (x == 8) begin
                checks++;
                if (PIX_VALID_O !== 1'b1) begin failures++; $display("FAIL stretch_valid_x5: got %b expected 1", PIX_VALID_O); end
            end
        end
        drive(1100, 0, 1'b0);
        checks++; if (BRAM_ADDR !== 18'd575) begin failures++; $display("FAIL stretch_addr_x1023: got %0d expected 575", BRAM_ADDR); end
        blank(4);
    endtask

    task automatic test_sync_delay();
        logic [9:0] hs_seen;
        logic [9:0] vs_seen;
        blank(4);
        for (int i = 0; i < 10; i++) begin
            VGA_HS_I = (i < 3);
            VGA_VS_I = (i == 1);
            drive(1100, 700, 1'b0);
            hs_seen[i] = VGA_HS_O;
            vs_seen[i] = VGA_VS_O;
        end
        VGA_HS_I = 1'b0;
        VGA_VS_I = 1'b0;
        checks++; if (hs_seen !== 10'b0000111000) begin failures++; $display("FAIL hs_delay: got %b expected 0000111000", hs_seen); end
        checks++; if (vs_seen !== 10'b0000010000) begin failures++; $display("FAIL vs_delay: got %b expected 0000010000", vs_seen); end
    endtask

    task automatic test_stretch_rows();
        MODE = 1'b0;
        blank(4);
        for (int y = 0; y < 599; y++) begin
            drive(0, y, 1'b1);
            drive(1023, y, 1'b1);
            if (y == 1) begin
                checks++; if (BRAM_ADDR !== 18'd0) begin failures++; $display("FAIL stretch_addr_0_1: got %0d expected 0", BRAM_ADDR); end
            end
            if (y == 2) begin
                checks++; if (BRAM_ADDR !== 18'd576) begin failures++; $display("FAIL stretch_addr_0_2: got %0d expected 576", BRAM_ADDR); end
            end
            blank(2);
        end
        for (int x = 0; x < 1024; x++) drive(x, 599, 1'b1);
        drive(1100, 599, 1'b0);
        checks++; if (BRAM_ADDR !== 18'd217727) begin failures++; $display("FAIL stretch_addr_1023_599: got %0d expected 217727", BRAM_ADDR); end
        blank(4);
    endtask

    task automatic test_native();
        MODE = 1'b1;
        blank(4);
        drive(0, 0, 1'b1);
        drive(575, 0, 1'b1);
        drive(600, 0, 1'b1);
        drive(1100, 0, 1'b0);
        checks++; if (BRAM_ADDR !== 18'd0) begin failures++; $display("FAIL native_addr_600_0: got %0d expected 0", BRAM_ADDR); end
        drive(1100, 0, 1'b0);
        checks++; if (PIX_VALID_O !== 1'b1) begin failures++; $display("FAIL native_valid_575_0: got %b expected 1", PIX_VALID_O); end
        checks++; if (PIX_O !== 8'hA4) begin failures++; $display("FAIL native_pix_575_0: got %h expected a4", PIX_O); end
        drive(1100, 0, 1'b0);
        checks++; if (PIX_O !== 8'h00) begin failures++; $display("FAIL native_pix_600_0: got %h expected 00", PIX_O); end
        checks++; if (PIX_VALID_O !== 1'b0) begin failures++; $display("FAIL native_valid_600_0: got %b expected 0", PIX_VALID_O); end
        blank(2);
        for (int y = 1; y < 3; y++) begin
            drive(0, y, 1'b1);
            drive(575, y, 1'b1);
            blank(2);
        end
        for (int x = 0; x < 11; x++) drive(x, 3, 1'b1);
        drive(1100, 3, 1'b0);
        checks++; if (BRAM_ADDR !== 18'd1738) begin failures++; $display("FAIL native_addr_10_3: got %0d expected 1738", BRAM_ADDR); end
        blank(4);
    endtask

    task automatic test_mode_toggle();
        MODE = 1'b0;
        blank(4);
        drive(0, 0, 1'b1);
        drive(1023, 0, 1'b1);
        blank(2);
        MODE = 1'b1;
        drive(0, 1, 1'b1);
        drive(1, 1, 1'b1);
        drive(2, 1, 1'b1);
        drive(1100, 1, 1'b0);
        checks++; if (BRAM_ADDR !== 18'd1) begin failures++; $display("FAIL toggle_midframe_addr_2_1: got %0d expected 1", BRAM_ADDR); end
        blank(4);
        drive(0, 0, 1'b1);
        drive(1, 0, 1'b1);
        drive(2, 0, 1'b1);
        drive(1100, 0, 1'b0);
        checks++; if (BRAM_ADDR !== 18'd2) begin failures++; $display("FAIL toggle_newframe_addr_2_0: got %0d expected 2", BRAM_ADDR); end
        MODE = 1'b0;
        blank(4);
    endtask

    task automatic test_enable();
        MODE = 1'b0;
        blank(4);
        for (int x = 0; x < 4; x++) drive(x, 0, 1'b1);
        ENABLE = 1'b0;
        for (int i = 0; i < 3; i++) drive(700, 300, 1'b1);
        checks++; if (BRAM_ADDR !== 18'd1) begin failures++; $display("FAIL enable_hold_addr: got %0d expected 1", BRAM_ADDR); end
        checks++; if (PIX_O !== 8'hA5) begin failures++; $display("FAIL enable_hold_pix: got %h expected a5", PIX_O); end
        ENABLE = 1'b1;
        drive(4, 0, 1'b1);
        drive(5, 0, 1'b1);
        checks++; if (BRAM_ADDR !== 18'd2) begin failures++; $display("FAIL enable_resume_addr_4_0: got %0d expected 2", BRAM_ADDR); end
        blank(4);
    endtask

    task automatic test_reset_midline();
        MODE = 1'b0;
        blank(4);
        for (int x = 0; x <= 300; x++) begin
            if (x == 300) RESET = 1'b1;
            drive(x, 0, 1'b1);
        end
        checks++; if (BRAM_ADDR !== 18'd0) begin failures++; $display("FAIL midreset_addr: got %0d expected 0", BRAM_ADDR); end
        checks++; if (PIX_O !== 8'h00) begin failures++; $display("FAIL midreset_pix: got %h expected 00", PIX_O); end
        checks++; if (PIX_VALID_O !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b expected 0", PIX_VALID_O); end
        RESET = 1'b0;
        for (int x = 301; x < 1024; x++) drive(x, 0, 1'b1);
        blank(4);
        for (int y = 0; y < 2; y++) begin
            drive(0, y, 1'b1);
            drive(1023, y, 1'b1);
            blank(2);
        end
        drive(0, 2, 1'b1);
        drive(1, 2, 1'b1);
        drive(2, 2, 1'b1);
        drive(1100, 2, 1'b0);
        checks++; if (BRAM_ADDR !== 18'd577) begin failures++; $display("FAIL midreset_recover_addr_2_2: got %0d expected 577", BRAM_ADDR); end
        blank(4);
    endtask

`ifdef HP2VGA_BORDER_EN
    task automatic test_border();
        logic [7:0] ep;
        MODE = 1'b0;
        blank(4);
        for (int y = 0; y < 100; y++) begin
            drive(0, y, 1'b1);
            drive(1023, y, 1'b1);
            blank(2);
        end
        for (int x = 0; x < 1024; x++) begin
            drive(x, 100, 1'b1);
            if (x == 3 || x == 515) begin
                ep = (x == 3) ? 8'hFF : 8'h45;
                checks++;
                if (PIX_O !== ep) begin failures++; $display("FAIL border_pix_x%0d: got %h expected %h", x - 3, PIX_O, ep); end
            end
        end
        blank(3);
        checks++; if (PIX_O !== 8'hFF) begin failures++; $display("FAIL border_pix_x1023: got %h expected ff", PIX_O); end
        blank(4);
    endtask
`endif

    initial begin
        RESET       = 1'b1;
        ENABLE      = 1'b1;
        MODE        = 1'b0;
        VGA_X       = 12'd1100;
        VGA_Y       = 12'd700;
        VGA_VISIBLE = 1'b0;
        VGA_HS_I    = 1'b0;
        VGA_VS_I    = 1'b0;
        #2;
        test_reset();
        test_stretch_line();
        test_sync_delay();
        test_stretch_rows();
        test_native();
        test_mode_toggle();
        test_enable();
        test_reset_midline();
`ifdef HP2VGA_BORDER_EN
        test_border();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
